// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment encodings, FSM state type and default dead-time for the 7-segment scan driver
package seg7_pkg;
  localparam int DEADTIME_DEFAULT = 64;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_e;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD to active-low 7-segment pattern (bit0=a .. bit6=g); codes 10..15 show a dash
//   i_bcd  4-bit BCD digit
//   o_seg  7-bit active-low segment pattern
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 3-digit multiplexed 7-segment driver with synchronized digit select and anode dead-time
//   i_clk            system clock, rising edge
//   i_rst            synchronous active-low reset
//   i_refresh_count  asynchronous digit-select index (3 = invalid, holds display blank)
//   i_digit0..2      BCD digits, digit0 least significant
//   i_dp             per-digit decimal point request, active-high
//   o_seg / o_dp     registered active-low segments and decimal point
//   o_an             registered active-low anodes, bit n = digit n
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros on digit2/digit1.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DEADTIME_CYCLES = DEADTIME_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_refresh_count,
  input  logic [3:0] i_digit0,
  input  logic [3:0] i_digit1,
  input  logic [3:0] i_digit2,
  input  logic [2:0] i_dp,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [2:0] o_an
);
  localparam logic [9:0] RELOAD = 10'(DEADTIME_CYCLES - 1);
  logic [1:0] s1_q, s2_q, idx_q, idx_d;
  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [3:0] sd0_q, sd1_q, sd2_q, sel_digit;
  logic [2:0] sdp_q, an_d;
  logic [6:0] dec_seg, seg_d;
  logic       accept, drive, lz, dp_d;
  // s1_q is the value s2_q takes next clock, so equality means the synchronized
  // index has been stable across two consecutive clocks
  assign accept = (s1_q == s2_q) && (s2_q != idx_q);
  always_comb begin
    idx_d   = accept ? s2_q : idx_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept || idx_d == 2'd3) begin
      state_d = ST_BLANK;
      cnt_d   = RELOAD;
    end else if (state_q == ST_BLANK) begin
      state_d = (cnt_q == 10'd0) ? ST_DRIVE : ST_BLANK;
      cnt_d   = (cnt_q == 10'd0) ? cnt_q : cnt_q - 10'd1;
    end
  end
  assign sel_digit = (idx_q == 2'd0) ? sd0_q : (idx_q == 2'd1) ? sd1_q : sd2_q;
  seg7_decode u_decode (
    .i_bcd (sel_digit),
    .o_seg (dec_seg)
  );
  always_comb begin
    drive = (state_q == ST_DRIVE) && (idx_q != 2'd3);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz = ((idx_q == 2'd2) && (sd2_q == 4'd0)) ||
         ((idx_q == 2'd1) && (sd2_q == 4'd0) && (sd1_q == 4'd0));
`else
    lz = 1'b0;
`endif
    an_d  = drive ? ~(3'b001 << idx_q) : 3'b111;
    seg_d = (drive && !lz) ? dec_seg : SEG_BLANK;
    // the low anode bit selects the matching dp request; all-off anodes give dp off
    dp_d  = ~|(sdp_q & ~an_d);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1_q    <= 2'd0;
      s2_q    <= 2'd0;
      idx_q   <= 2'd0;
      state_q <= ST_BLANK;
      cnt_q   <= RELOAD;
      sd0_q   <= 4'd0;
      sd1_q   <= 4'd0;
      sd2_q   <= 4'd0;
      sdp_q   <= 3'd0;
      o_an    <= 3'b111;
      o_seg   <= SEG_BLANK;
      o_dp    <= 1'b1;
    end else begin
      s1_q    <= i_refresh_count;
      s2_q    <= s1_q;
      idx_q   <= idx_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // a new frame starts at digit 0, so all digits are sampled together there
      if (accept && s2_q == 2'd0) begin
        sd0_q <= i_digit0;
        sd1_q <= i_digit1;
        sd2_q <= i_digit2;
        sdp_q <= i_dp;
      end
      o_an    <= an_d;
      o_seg   <= seg_d;
      o_dp    <= dp_d;
    end
  end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter: DEADTIME_CYCLES, default 64, all-anodes-off clocks inserted at each digit change (range 1..1023).
REQ-002 i_clk  input  1  system clock; all logic on rising edge.
REQ-003 i_rst  input  1  reset, synchronous and active-low.
REQ-004 i_refresh_count  input  2  digit-select index from the refresh counter (0..2 valid, 3 invalid); asynchronous to i_clk.
REQ-005 i_digit0 / i_digit1 / i_digit2  input  4 each  BCD digits; digit0 is least significant, digit2 most significant.
REQ-006 i_dp  input  3  decimal point request per digit, bit n = digit n, active-high.
REQ-007 o_seg  output  7  segments, active-low, bit0=a .. bit6=g.
REQ-008 o_dp  output  1  decimal point, active-low.
REQ-009 o_an  output  3  digit anodes, active-low, bit n = digit n.

Function
REQ-010 i_refresh_count shall pass through a 2-flop synchronizer; the synchronized value shall be accepted only when equal on two consecutive clocks and different from the current accepted index.
REQ-011 Accepted index shall update exactly 3 clocks after a clean input change.
REQ-012 FSM states: BLANK, DRIVE; reset enters BLANK with accepted index 0 and dead-time counter loaded.
REQ-013 On every accepted index change, FSM shall enter BLANK and reload the counter, including when already in BLANK (counter restarts).
REQ-014 In BLANK, o_an=3'b111, o_seg=7'h7F, o_dp=1, for exactly DEADTIME_CYCLES clocks, then DRIVE.
REQ-015 In DRIVE with index n (0..2), o_an shall have only bit n low and o_seg/o_dp shall show shadow digit n; all outputs registered.
REQ-016 Accepted index 3 shall hold the FSM in BLANK (counter held at reload value) until a valid index is accepted.
REQ-017 Shadow registers (three digits + dp) shall capture i_digit0..2 and i_dp on the clock an accepted index of 0 takes effect, so a scan frame never mixes two input values.
REQ-018 Encoding: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10; BCD 10..15 shall display dash 7'h3F.
REQ-019 o_dp in DRIVE shall equal ~shadow_dp[n].

Reset
REQ-020 While i_rst=0 at a clock edge: o_an=3'b111, o_seg=7'h7F, o_dp=1, shadow registers 0, synchronizer flops 0, state BLANK.
REQ-021 Reset asserted mid-DRIVE or mid-BLANK shall produce the reset values on the next clock; no partial dead-time survives.

Configuration
REQ-022 Macro SEG7_LEADING_ZERO_BLANK_EN defined: digit2 shows 7'h7F when shadow digit2=0; digit1 shows 7'h7F when shadow digit2=0 and digit1=0; digit0 never blanked; anode still asserted; dp unaffected.
REQ-023 Macro undefined: all digits always decoded per REQ-018.

Structure
REQ-024 Package seg7_pkg shall hold segment encoding constants (digits, dash, blank), FSM state type, default DEADTIME_CYCLES.
REQ-025 Sub-module seg7_decode (combinational, 4-bit BCD in, 7-bit active-low segments out) shall be instantiated once on the selected shadow digit.

Verification
REQ-026 Reset held 5 clocks, any inputs -> o_an=3'b111, o_seg=7'h7F, o_dp=1 throughout and one clock after release.
REQ-027 DEADTIME_CYCLES=4, digits 5/1/0, i_refresh_count 0->1 -> o_an=3'b111 for exactly 4 clocks starting 4 clocks after the change, then o_an=3'b101, o_seg=7'h79.
REQ-028 i_digit0 changed 3->7 while index=1 -> digit0 still shows 7'h30 until next accepted index 0, then 7'h78.
REQ-029 Index 3 applied for 100 clocks -> outputs blank the whole time; index 2 then shows digit2 after dead-time.
REQ-030 Macro defined, digits 0/0/4 (digit2..0) -> digit2 and digit1 show 7'h7F with anode low, digit0 shows 7'h19; macro undefined -> 7'h40, 7'h40, 7'h19.
REQ-031 1-clock glitch on i_refresh_count 0->2->0 -> accepted index unchanged, no BLANK entry; digit 12 with i_dp[0]=1 -> o_seg=7'h3F, o_dp=0.
